skinny_sbox_layer_scheduler: RTL

- Serial controller that time-shares one masked Skinny 4-bit Sbox instance (HPC2, d+1 shares, clock-gated, fixed latency) across all 16 nibbles of a Skinny-64 state.
- Per nibble it requests fresh randomness from the PRNG, drives the Sbox, waits the Sbox latency, then writes the result back in place.
- Sits between the round-function datapath (start/done) and the shared Sbox plus PRNG.

---
 rtl/skinny_sbox_layer_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/skinny_sbox_layer_scheduler.sv
// Serial scheduler that time-shares one masked Skinny 4-bit Sbox over all nibbles of the state.
// Each nibble: fetch fresh randomness, hold the Sbox inputs for LATENCY cycles, write back in place.
module skinny_sbox_layer_scheduler #(
  parameter int SECURITY_ORDER = 4,
  parameter int NIBBLES        = 16,
  parameter int LATENCY        = 5,
  parameter int FRESH_W        = 4 * SECURITY_ORDER * (SECURITY_ORDER + 1) / 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [4*NIBBLES*(SECURITY_ORDER+1)-1:0]    state_in,
  output logic                                       busy,
  output logic                                       done,
  output logic [4*NIBBLES*(SECURITY_ORDER+1)-1:0]    state_out,
  output logic [4*(SECURITY_ORDER+1)-1:0]            sbox_x,
  output logic [FRESH_W-1:0]                         sbox_fresh,
  input  logic [4*(SECURITY_ORDER+1)-1:0]            sbox_y,
  output logic                                       fresh_req,
  input  logic                                       fresh_valid,
  input  logic [FRESH_W-1:0]                         fresh_in
);

  localparam int SHARES  = SECURITY_ORDER + 1;
  localparam int SHARE_W = 4 * NIBBLES;
  localparam int STATE_W = SHARE_W * SHARES;
  localparam int LANE_W  = 4 * SHARES;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RUN,
    CAPTURE,
    DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_merged;
  logic [LANE_W-1:0]  lane_sel;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;

  // Each share lane only ever connects to its own nibble slot, so shares never mix.
  always_comb begin
    lane_sel     = '0;
    state_merged = state_reg;
    for (int s = 0; s < SHARES; s++) begin
      lane_sel[4*s +: 4]                               = state_reg[s*SHARE_W + 4*int'(idx) +: 4];
      state_merged[s*SHARE_W + 4*int'(idx) +: 4]       = sbox_y[4*s +: 4];
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    fresh_req = (state_q == FETCH);
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (fresh_valid) state_d = RUN;
      RUN:     if (cnt == LAST_CNT) state_d = CAPTURE;
      CAPTURE: state_d = (idx == LAST_IDX) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // The last capture also loads state_out so the result is already valid while done is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= '0;
      state_out  <= '0;
      sbox_x     <= '0;
      sbox_fresh <= '0;
      idx        <= '0;
      cnt        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_reg <= state_in;
            idx       <= '0;
          end
        end
        FETCH: begin
          if (fresh_valid) begin
            sbox_fresh <= fresh_in;
            sbox_x     <= lane_sel;
            cnt        <= '0;
          end
        end
        RUN: cnt <= cnt + 1'b1;
        CAPTURE: begin
          state_reg <= state_merged;
          if (idx == LAST_IDX) state_out <= state_merged;
          else                 idx       <= idx + 1'b1;
        end
        DONE: begin
          sbox_x     <= '0;
          sbox_fresh <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
